nco_sweep_ctrl: RTL and testbench
=================================

// Module: nco_sweep_ctrl
// PURPOSE
//  Frequency-sweep scheduler for the NCO. Sequences the 32-bit frequency tuning word
//  (FTW) into the phase accumulator, which feeds the 32->16 quantizer and the phase/amplitude path.
//  Steps from a start FTW to a stop FTW in fixed increments, holding each value for a
//  programmable dwell. Pulses an accumulator clear at sweep start. Supports single-shot, loop, pause and abort.
// PARAMETERS
//  FTW_W    32  width of FTW, start/step/stop words
//  DWELL_W  16  width of dwell counter (cycles per FTW value)
// PORTS
//  clk        in   1        system clock, all logic on rising edge
//  rst        in   1        asynchronous, active-high reset
//  cfg_valid  in   1        config word set valid
//  cfg_ready  out  1        config may be accepted (high only in IDLE)
//  cfg_start  in   FTW_W    first FTW of sweep
//  cfg_step   in   FTW_W    unsigned increment per step
//  cfg_stop   in   FTW_W    last allowed FTW (inclusive, unsigned)
//  cfg_dwell  in   DWELL_W  cycles each FTW is held; 0 treated as 1
//  cfg_loop   in   1        0 = single sweep, 1 = restart at cfg_start forever
//  go         in   1        start sweep (level sampled, acts only in IDLE)
//  pause      in   1        freeze sweep while high
//  abort      in   1        terminate sweep immediately
//  ftw        out  FTW_W    registered tuning word to phase accumulator
//  ftw_valid  out  1        accumulator should advance by ftw this cycle
//  acc_clr    out  1        1-cycle pulse: clear phase accumulator
//  busy       out  1        high in RUN, PAUSE, DONE
//  done       out  1        1-cycle pulse at end of single sweep
// BEHAVIOUR
//  Reset: state=IDLE; ftw=0, ftw_valid=0, acc_clr=0, busy=0, done=0, cfg_ready=1,
//   shadow regs=0, cfg_loaded=0. Reset mid-sweep takes effect immediately; no done pulse.
//  All outputs registered. States IDLE, RUN, PAUSE, DONE.
//  IDLE: cfg_valid&cfg_ready -> shadow regs captured at edge, cfg_loaded=1. If cfg_valid and go
//   coincide, config captured and go ignored that cycle. go with cfg_loaded=0 is ignored.
//  IDLE, go, cfg_loaded, !abort (cycle T): at edge T+1 -> RUN, ftw=start, ftw_valid=1,
//   acc_clr=1 (T+1 only), busy=1, dwell_cnt=max(dwell,1).
//  RUN: dwell_cnt decrements each cycle. Each FTW value is presented exactly max(dwell,1) cycles.
//   On the last dwell cycle compute next = {1'b0,ftw}+step (FTW_W+1 bits). The value is in range
//   iff no carry, next<=stop and step!=0.
//   In range: ftw<=next, reload dwell_cnt.
//   Out of range with loop=1: ftw<=start, reload dwell_cnt; no acc_clr.
//   Out of range with loop=0: -> DONE.
//  step=0: single mode ends after one dwell; loop mode holds start until abort.
//   start>stop: single mode ends after one dwell of start.
//  pause high in RUN: -> PAUSE next edge. dwell_cnt and ftw frozen, ftw_valid=0.
//   pause low -> RUN, resume remaining dwell; the paused cycle does not count.
//  DONE (1 cycle): ftw_valid=0, done=1, busy=1; next edge -> IDLE, ftw=0, busy=0.
//  abort: highest priority. In any non-IDLE state -> IDLE at next edge: ftw=0, ftw_valid=0,
//   busy=0, done not pulsed. Shadow config is retained.
//  cfg_ready=0 in RUN/PAUSE/DONE. Config changes during a sweep are impossible.
// TESTING
//  T1 start=0x1000_0000 step=0x0100_0000 stop=0x1300_0000 dwell=3 loop=0, go@T ->
//     ftw 0x1000_0000,0x1100_0000,0x1200_0000,0x1300_0000, 3 cycles each (T+1..T+12);
//     acc_clr only at T+1; done=1 at T+13; IDLE, busy=0 at T+14.
//  T2 same config, loop=1 -> after 0x1300_0000 ftw returns to 0x1000_0000 with no gap and
//     no acc_clr; abort at T+20 -> ftw=0, ftw_valid=0 at T+21, no done.
//  T3 start=0xF000_0000 step=0x1000_0000 stop=0xFFFF_FFFF dwell=0 -> single cycle of
//     0xF000_0000 (carry detected), then DONE.
//  T4 T1 config, pause high 4 cycles from T+5 -> ftw_valid low 4 cycles, ftw frozen at
//     0x1100_0000, done shifts to T+17.
//  T5 go with no config loaded -> stays IDLE. cfg_valid+go same cycle -> config taken,
//     no start. go next cycle -> starts.
//  T6 assert rst async at T+6 of T1 -> all outputs at reset values before next edge;
//     sweep does not resume; cfg_loaded=0.

Source files
------------

// File: rtl/nco_sweep_ctrl.sv
// NCO frequency-sweep scheduler: steps a tuning word from start to stop in fixed
// increments, holding each value for a programmable dwell, with loop/pause/abort.
module nco_sweep_ctrl #(
  parameter int FTW_W   = 32,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [FTW_W-1:0]   cfg_start,
  input  logic [FTW_W-1:0]   cfg_step,
  input  logic [FTW_W-1:0]   cfg_stop,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_loop,
  input  logic               go,
  input  logic               pause,
  input  logic               abort,
  output logic [FTW_W-1:0]   ftw,
  output logic               ftw_valid,
  output logic               acc_clr,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  typedef struct packed {
    logic [FTW_W-1:0]   start;
    logic [FTW_W-1:0]   incr;
    logic [FTW_W-1:0]   stop;
    logic [DWELL_W-1:0] dwell;
    logic               loop;
  } cfg_t;

  state_t             state, state_n;
  cfg_t               cfg_q, cfg_n;
  logic               cfg_loaded, cfg_loaded_n;
  logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_n, dwell_load;
  logic [FTW_W-1:0]   ftw_n;
  logic               ftw_valid_n, acc_clr_n, busy_n, done_n, cfg_ready_n;
  logic [FTW_W:0]     ftw_sum;
  logic               in_range;

  assign dwell_load = (cfg_q.dwell == '0) ? DWELL_W'(1) : cfg_q.dwell;
  // Extra bit catches wrap past the top of the FTW range.
  assign ftw_sum    = {1'b0, ftw} + {1'b0, cfg_q.incr};
  assign in_range   = !ftw_sum[FTW_W] && (ftw_sum[FTW_W-1:0] <= cfg_q.stop) &&
                      (cfg_q.incr != '0);

  always_comb begin
    state_n      = state;
    cfg_n        = cfg_q;
    cfg_loaded_n = cfg_loaded;
    dwell_cnt_n  = dwell_cnt;
    ftw_n        = ftw;
    ftw_valid_n  = 1'b0;
    acc_clr_n    = 1'b0;
    done_n       = 1'b0;
    case (state)
      IDLE: begin
        ftw_n = '0;
        if (cfg_valid) begin
          cfg_n.start  = cfg_start;
          cfg_n.incr   = cfg_step;
          cfg_n.stop   = cfg_stop;
          cfg_n.dwell  = cfg_dwell;
          cfg_n.loop   = cfg_loop;
          cfg_loaded_n = 1'b1;
        end else if (go && cfg_loaded && !abort) begin
          state_n     = RUN;
          ftw_n       = cfg_q.start;
          ftw_valid_n = 1'b1;
          acc_clr_n   = 1'b1;
          dwell_cnt_n = dwell_load;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
          ftw_n   = '0;
        end else begin
          // The cycle in which pause is seen was already presented, so it still counts.
          if (dwell_cnt > DWELL_W'(1)) begin
            dwell_cnt_n = dwell_cnt - DWELL_W'(1);
          end else if (in_range) begin
            ftw_n       = ftw_sum[FTW_W-1:0];
            dwell_cnt_n = dwell_load;
          end else if (cfg_q.loop) begin
            ftw_n       = cfg_q.start;
            dwell_cnt_n = dwell_load;
          end else begin
            state_n = DONE;
            done_n  = 1'b1;
          end
          if (state_n == RUN) begin
            state_n     = pause ? PAUSE : RUN;
            ftw_valid_n = !pause;
          end
        end
      end
      PAUSE: begin
        if (abort) begin
          state_n = IDLE;
          ftw_n   = '0;
        end else if (!pause) begin
          state_n     = RUN;
          ftw_valid_n = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        ftw_n   = '0;
      end
      default: begin
        state_n = IDLE;
        ftw_n   = '0;
      end
    endcase
    busy_n      = (state_n != IDLE);
    cfg_ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cfg_q      <= '0;
      cfg_loaded <= 1'b0;
      dwell_cnt  <= '0;
      ftw        <= '0;
      ftw_valid  <= 1'b0;
      acc_clr    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_ready  <= 1'b1;
    end else begin
      state      <= state_n;
      cfg_q      <= cfg_n;
      cfg_loaded <= cfg_loaded_n;
      dwell_cnt  <= dwell_cnt_n;
      ftw        <= ftw_n;
      ftw_valid  <= ftw_valid_n;
      acc_clr    <= acc_clr_n;
      busy       <= busy_n;
      done       <= done_n;
      cfg_ready  <= cfg_ready_n;
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl: stimulus queues cycle-stamped expected outputs,
// a negedge monitor pops and compares whenever ftw_valid, acc_clr or done is seen.
module tb_nco_sweep_ctrl;
  localparam int FW = 32;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid, cfg_ready, cfg_loop, go, pause, abort;
  logic [FW-1:0] cfg_start, cfg_step, cfg_stop, ftw;
  logic [DW-1:0] cfg_dwell;
  logic          ftw_valid, acc_clr, busy, done;

  nco_sweep_ctrl #(.FTW_W(FW), .DWELL_W(DW)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start(cfg_start), .cfg_step(cfg_step), .cfg_stop(cfg_stop),
    .cfg_dwell(cfg_dwell), .cfg_loop(cfg_loop), .go(go), .pause(pause),
    .abort(abort), .ftw(ftw), .ftw_valid(ftw_valid), .acc_clr(acc_clr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] ftw;
    logic        clr;
    logic        dn;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_v(int c, logic [31:0] f, logic clr);
    exp_t e;
    e.cyc = c; e.ftw = f; e.clr = clr; e.dn = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_d(int c);
    exp_t e;
    e.cyc = c; e.ftw = 32'h0; e.clr = 1'b0; e.dn = 1'b1;
    sb.push_back(e);
  endtask

  // T1 pattern: 0x1000_0000 + i*0x0100_0000, three cycles each, clear on the first.
  task automatic push_t1(int t, int n);
    for (int k = 1; k <= n; k++)
      push_v(t + k, 32'h1000_0000 + ((k - 1) / 3) * 32'h0100_0000, k == 1);
  endtask

  task automatic at_cyc(int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic load_cfg(logic [31:0] s, logic [31:0] st, logic [31:0] sp,
                          logic [15:0] d, logic l);
    @(negedge clk);
    cfg_start = s; cfg_step = st; cfg_stop = sp; cfg_dwell = d; cfg_loop = l;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic drain(string nm);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending outputs want 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_reset(string p);
    chk({p, "_ftw"}, ftw, 0);
    chk({p, "_ftw_valid"}, ftw_valid, 0);
    chk({p, "_acc_clr"}, acc_clr, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_cfg_ready"}, cfg_ready, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (ftw_valid || acc_clr || done)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: cyc %0d ftw %0h v%0b clr%0b done%0b, want no output",
                 cyc, ftw, ftw_valid, acc_clr, done);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || ftw_valid !== !e.dn || acc_clr !== e.clr || done !== e.dn ||
            (!e.dn && ftw !== e.ftw)) begin
          errors++;
          $display("FAIL sb_out: got cyc %0d ftw %0h v%0b clr%0b done%0b want cyc %0d ftw %0h v%0b clr%0b done%0b",
                   cyc, ftw, ftw_valid, acc_clr, done, e.cyc, e.ftw, !e.dn, e.clr, e.dn);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    cfg_valid = 0; cfg_loop = 0; go = 0; pause = 0; abort = 0;
    cfg_start = 0; cfg_step = 0; cfg_stop = 0; cfg_dwell = 0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    // go without config, then config+go together: neither may start
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    repeat (3) @(negedge clk);
    chk("noload_busy", busy, 0);
    chk("noload_ready", cfg_ready, 1);
    @(negedge clk);
    cfg_start = 32'h1000_0000; cfg_step = 32'h0100_0000; cfg_stop = 32'h1300_0000;
    cfg_dwell = 16'd3; cfg_loop = 1'b0; cfg_valid = 1'b1; go = 1'b1;
    @(negedge clk); cfg_valid = 1'b0; go = 1'b0;
    chk("cfg_go_busy", busy, 0);
    repeat (2) @(negedge clk);
    chk("cfg_go_busy2", busy, 0);

    // single sweep
    @(negedge clk); t = cyc;
    push_t1(t, 12); push_d(t + 13);
    go = 1'b1;
    @(negedge clk); go = 1'b0;
    at_cyc(t + 5);
    chk("t1_busy", busy, 1);
    chk("t1_ready", cfg_ready, 0);
    at_cyc(t + 13);
    chk("t1_done_busy", busy, 1);
    at_cyc(t + 14);
    chk("t1_end_busy", busy, 0);
    chk("t1_end_ready", cfg_ready, 1);
    chk("t1_end_ftw", ftw, 0);
    drain("t1");

    // loop sweep, abort at T+20
    load_cfg(32'h1000_0000, 32'h0100_0000, 32'h1300_0000, 16'd3, 1'b1);
    @(negedge clk); t = cyc;
    for (int k = 1; k <= 20; k++)
      push_v(t + k, 32'h1000_0000 + (((k - 1) / 3) % 4) * 32'h0100_0000, k == 1);
    go = 1'b1;
    @(negedge clk); go = 1'b0;
    at_cyc(t + 20); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("t2_abort_ftw", ftw, 0);
    chk("t2_abort_valid", ftw_valid, 0);
    chk("t2_abort_busy", busy, 0);
    repeat (3) @(negedge clk);
    drain("t2");

    // pause for 4 cycles from T+5
    load_cfg(32'h1000_0000, 32'h0100_0000, 32'h1300_0000, 16'd3, 1'b0);
    @(negedge clk); t = cyc;
    for (int j = 0; j < 3; j++) push_v(t + 1 + j, 32'h1000_0000, j == 0);
    push_v(t + 4, 32'h1100_0000, 0); push_v(t + 5, 32'h1100_0000, 0);
    push_v(t + 10, 32'h1100_0000, 0);
    for (int j = 0; j < 3; j++) push_v(t + 11 + j, 32'h1200_0000, 0);
    for (int j = 0; j < 3; j++) push_v(t + 14 + j, 32'h1300_0000, 0);
    push_d(t + 17);
    go = 1'b1;
    @(negedge clk); go = 1'b0;
    at_cyc(t + 5); pause = 1'b1;
    at_cyc(t + 7);
    chk("t4_pause_ftw", ftw, 32'h1100_0000);
    chk("t4_pause_valid", ftw_valid, 0);
    chk("t4_pause_busy", busy, 1);
    at_cyc(t + 9); pause = 1'b0;
    at_cyc(t + 18);
    chk("t4_end_busy", busy, 0);
    drain("t4");

    // carry out of the top of the range ends after one cycle
    load_cfg(32'hF000_0000, 32'h1000_0000, 32'hFFFF_FFFF, 16'd0, 1'b0);
    @(negedge clk); t = cyc;
    push_v(t + 1, 32'hF000_0000, 1); push_d(t + 2);
    go = 1'b1;
    @(negedge clk); go = 1'b0;
    at_cyc(t + 3);
    chk("t3_end_busy", busy, 0);
    drain("t3");

    // step 0 in loop mode holds start until abort
    load_cfg(32'h0000_0055, 32'h0, 32'h0000_FFFF, 16'd2, 1'b1);
    @(negedge clk); t = cyc;
    for (int k = 1; k <= 6; k++) push_v(t + k, 32'h0000_0055, k == 1);
    go = 1'b1;
    @(negedge clk); go = 1'b0;
    at_cyc(t + 6); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("step0_busy", busy, 0);
    repeat (2) @(negedge clk);
    drain("step0");

    // start above stop: one dwell of start then done
    load_cfg(32'h0000_0200, 32'h1, 32'h0000_0100, 16'd2, 1'b0);
    @(negedge clk); t = cyc;
    push_v(t + 1, 32'h0000_0200, 1); push_v(t + 2, 32'h0000_0200, 0); push_d(t + 3);
    go = 1'b1;
    @(negedge clk); go = 1'b0;
    at_cyc(t + 4);
    chk("rev_end_busy", busy, 0);
    drain("rev");

    // async reset mid-sweep clears outputs and the loaded config
    load_cfg(32'h1000_0000, 32'h0100_0000, 32'h1300_0000, 16'd3, 1'b0);
    @(negedge clk); t = cyc;
    push_t1(t, 6);
    go = 1'b1;
    @(negedge clk); go = 1'b0;
    at_cyc(t + 6);
    #2 rst = 1'b1;
    #1 chk_reset("t6");
    @(negedge clk); rst = 1'b0;
    drain("t6");
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_noresume_busy", busy, 0);
    chk("t6_noresume_valid", ftw_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
